apb_req_arbiter: RTL and testbench

- Round-robin arbiter that shares the single APB master transfer interface among NUM_REQ local requesters.
- Each requester gets one complete APB transfer per grant.
- For each grant the block latches the winner's command, drives transfer and the S* command bus into the APB master, and watches PSEL/PENABLE/PREADY for completion.
- It returns PRDATA/PSLVERR to the winner, with a watchdog that aborts stalled transfers.

---
 rtl/apb_req_arbiter.sv | 173 +++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master transfer port among NUM_REQ
// requesters, with a watchdog that aborts stalled transfers.
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif
`ifndef APB_STRB_WIDTH
`define APB_STRB_WIDTH 4
`endif
`ifndef APB_PROT_WIDTH
`define APB_PROT_WIDTH 3
`endif

module apb_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = `APB_ADDR_WIDTH,
  parameter int DATA_W  = `APB_DATA_WIDTH,
  parameter int STRB_W  = `APB_STRB_WIDTH,
  parameter int PROT_W  = `APB_PROT_WIDTH,
  parameter int TIMEOUT = 16
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  input  logic [NUM_REQ*STRB_W-1:0]  req_strb,
  input  logic [NUM_REQ*PROT_W-1:0]  req_prot,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_slverr,
  output logic                       rsp_timeout,
  output logic                       transfer,
  output logic                       SWRITE,
  output logic [ADDR_W-1:0]          SADDR,
  output logic [DATA_W-1:0]          SWDATA,
  output logic [STRB_W-1:0]          SSTRB,
  output logic [PROT_W-1:0]          SPROT,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PREADY,
  input  logic [DATA_W-1:0]          PRDATA,
  input  logic                       PSLVERR
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic [WD_W-1:0]    watchdog;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   win_next;
  logic [NUM_REQ-1:0] win_oh;
  logic [NUM_REQ-1:0] owner_oh;
  logic               setup_seen;
  logic               done;
  logic               expired;

  function automatic logic [IDX_W-1:0] wrap_add(
    input logic [IDX_W-1:0] base,
    input int               ofs
  );
    int s;
    s = int'(base) + ofs;
    if (s >= NUM_REQ)
      s = s - NUM_REQ;
    return s[IDX_W-1:0];
  endfunction

  // search upward from rr_ptr, wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_valid[wrap_add(rr_ptr, i)]) begin
        win_found = 1'b1;
        win_idx   = wrap_add(rr_ptr, i);
      end
    end
  end

  assign win_next   = wrap_add(win_idx, 1);
  assign win_oh     = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
  assign owner_oh   = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
  assign setup_seen = PSEL & ~PENABLE;
  assign done       = PSEL & PENABLE & PREADY;
  assign expired    = (watchdog == WD_W'(TIMEOUT - 1));

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      watchdog    <= '0;
      req_ack     <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
      transfer    <= 1'b0;
      SWRITE      <= 1'b0;
      SADDR       <= '0;
      SWDATA      <= '0;
      SSTRB       <= '0;
      SPROT       <= '0;
    end else begin
      req_ack   <= '0;
      rsp_valid <= '0;
      unique case (state)
        IDLE: begin
          if (win_found) begin
            owner    <= win_idx;
            rr_ptr   <= win_next;
            req_ack  <= win_oh;
            transfer <= 1'b1;
            SWRITE   <= req_write[win_idx];
            SADDR    <= req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
            SWDATA   <= req_wdata[int'(win_idx)*DATA_W +: DATA_W];
            SSTRB    <= req_strb[int'(win_idx)*STRB_W +: STRB_W];
            SPROT    <= req_prot[int'(win_idx)*PROT_W +: PROT_W];
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (setup_seen) begin
            transfer <= 1'b0;
            watchdog <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          watchdog <= watchdog + 1'b1;
          // completion takes priority over a coincident expiry
          if (done) begin
            rsp_rdata   <= PRDATA;
            rsp_slverr  <= PSLVERR;
            rsp_timeout <= 1'b0;
            rsp_valid   <= owner_oh;
            state       <= RESP;
          end else if (expired) begin
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_valid   <= owner_oh;
            state       <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with a small APB master and
// memory slave model behind the S* command bus.
module tb_apb_req_arbiter;

  logic         PCLK;
  logic         PRESET;
  logic [3:0]   req_valid;
  logic [3:0]   req_write;
  logic [127:0] req_addr;
  logic [127:0] req_wdata;
  logic [15:0]  req_strb;
  logic [11:0]  req_prot;
  logic [3:0]   req_ack;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         rsp_slverr;
  logic         rsp_timeout;
  logic         transfer;
  logic         SWRITE;
  logic [31:0]  SADDR;
  logic [31:0]  SWDATA;
  logic [3:0]   SSTRB;
  logic [2:0]   SPROT;
  logic         PSEL;
  logic         PENABLE;
  logic         PREADY;
  logic [31:0]  PRDATA;
  logic         PSLVERR;

  logic         stall;
  logic [31:0]  mem [16];
  int           cyc;
  int           vecs;
  int           errs;

  apb_req_arbiter #(
    .NUM_REQ(4), .ADDR_W(32), .DATA_W(32),
    .STRB_W(4), .PROT_W(3), .TIMEOUT(16)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_strb(req_strb), .req_prot(req_prot),
    .req_ack(req_ack), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .rsp_timeout(rsp_timeout), .transfer(transfer),
    .SWRITE(SWRITE), .SADDR(SADDR), .SWDATA(SWDATA),
    .SSTRB(SSTRB), .SPROT(SPROT),
    .PSEL(PSEL), .PENABLE(PENABLE), .PREADY(PREADY),
    .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) cyc <= cyc + 1;

  // APB master + zero-wait memory slave; APB4 read with strobes is an error
  assign PREADY  = PSEL & PENABLE & ~stall;
  assign PRDATA  = mem[SADDR[5:2]];
  assign PSLVERR = PSEL & PENABLE & ~SWRITE & (SSTRB != 4'h0);

  always @(posedge PCLK) begin
    if (PRESET) begin
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
    end else if (!PSEL) begin
      if (transfer) begin
        PSEL    <= 1'b1;
        PENABLE <= 1'b0;
      end
    end else if (!PENABLE) begin
      PENABLE <= 1'b1;
    end else if (PREADY) begin
      if (SWRITE)
        for (int b = 0; b < 4; b++)
          if (SSTRB[b]) mem[SADDR[5:2]][b*8 +: 8] <= SWDATA[b*8 +: 8];
      PSEL    <= transfer;
      PENABLE <= 1'b0;
    end
  end

  task automatic set_payload(input int idx, input logic wr,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [2:0] p);
    req_write[idx]          = wr;
    req_addr[idx*32 +: 32]  = a;
    req_wdata[idx*32 +: 32] = d;
    req_strb[idx*4 +: 4]    = s;
    req_prot[idx*3 +: 3]    = p;
  endtask

  task automatic do_reset();
    PRESET    = 1'b1;
    req_valid = 4'h0;
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
  endtask

  task automatic drain(input int n);
    req_valid = 4'h0;
    repeat (n) @(negedge PCLK);
  endtask

  // one transfer for requester idx; reports what the DUT returned
  task automatic run_xfer(input int idx, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s,
                          output logic [3:0] ack, output int lat,
                          output logic [31:0] sa,
                          output logic [3:0] rv, output logic [31:0] rd,
                          output logic se, output logic to,
                          output int wait_n);
    set_payload(idx, wr, a, d, s, 3'd0);
    req_valid[idx] = 1'b1;
    ack = 4'h0; lat = 0; sa = 32'h0;
    for (int k = 1; k <= 20 && ack == 4'h0; k++) begin
      @(negedge PCLK);
      if (req_ack != 4'h0) begin
        ack = req_ack; lat = k; sa = SADDR;
      end
    end
    req_valid = 4'h0;
    rv = 4'h0; rd = 32'h0; se = 1'b0; to = 1'b0; wait_n = 0;
    for (int k = 0; k < 100 && rv == 4'h0; k++) begin
      @(negedge PCLK);
      if (rsp_valid != 4'h0) begin
        rv = rsp_valid; rd = rsp_rdata;
        se = rsp_slverr; to = rsp_timeout;
      end else if (!transfer) begin
        wait_n++;
      end
    end
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    req_valid = 4'h0;
    repeat (3) @(negedge PCLK);
    vecs++;
    if ({req_ack, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
         transfer, SWRITE, SADDR, SWDATA, SSTRB, SPROT} !== 115'h0) begin
      errs++;
      $display("FAIL reset_outputs: got ack=%b rv=%b rd=%h tr=%b sa=%h, want all 0",
               req_ack, rsp_valid, rsp_rdata, transfer, SADDR);
    end
    PRESET = 1'b0;
    @(negedge PCLK);
    vecs++;
    if (transfer !== 1'b0 || req_ack !== 4'h0) begin
      errs++;
      $display("FAIL reset_idle: got tr=%b ack=%b, want 0/0000",
               transfer, req_ack);
    end
  endtask

  task automatic test_single_write();
    logic [3:0] ack, rv; logic [31:0] sa, rd; logic se, to; int lat, wn;
    run_xfer(2, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF,
             ack, lat, sa, rv, rd, se, to, wn);
    vecs++;
    if (ack !== 4'b0100 || lat != 1) begin
      errs++;
      $display("FAIL wr_ack: got %b at %0d, want 0100 at 1", ack, lat);
    end
    vecs++;
    if (sa !== 32'h10) begin
      errs++;
      $display("FAIL wr_saddr: got %h, want 00000010", sa);
    end
    vecs++;
    if (wn != 1) begin
      errs++;
      $display("FAIL wr_wait_cycles: got %0d, want 1", wn);
    end
    vecs++;
    if (rv !== 4'b0100 || se !== 1'b0 || to !== 1'b0) begin
      errs++;
      $display("FAIL wr_rsp: got rv=%b se=%b to=%b, want 0100 0 0",
               rv, se, to);
    end
  endtask

  task automatic test_read_back();
    logic [3:0] ack, rv; logic [31:0] sa, rd; logic se, to; int lat, wn;
    @(negedge PCLK);
    run_xfer(0, 1'b0, 32'h10, 32'h0, 4'h0,
             ack, lat, sa, rv, rd, se, to, wn);
    vecs++;
    if (rv !== 4'b0001 || rd !== 32'hDEADBEEF || se !== 1'b0) begin
      errs++;
      $display("FAIL rd_back: got rv=%b rd=%h se=%b, want 0001 deadbeef 0",
               rv, rd, se);
    end
  endtask

  task automatic test_slave_error();
    logic [3:0] ack, rv; logic [31:0] sa, rd; logic se, to; int lat, wn;
    @(negedge PCLK);
    run_xfer(1, 1'b0, 32'h20, 32'h0, 4'h3,
             ack, lat, sa, rv, rd, se, to, wn);
    vecs++;
    if (rv !== 4'b0010 || se !== 1'b1 || to !== 1'b0) begin
      errs++;
      $display("FAIL slverr_rsp: got rv=%b se=%b to=%b, want 0010 1 0",
               rv, se, to);
    end
    @(negedge PCLK);
    run_xfer(3, 1'b1, 32'h24, 32'h12345678, 4'hF,
             ack, lat, sa, rv, rd, se, to, wn);
    vecs++;
    if (ack !== 4'b1000 || rv !== 4'b1000 || se !== 1'b0) begin
      errs++;
      $display("FAIL after_err: got ack=%b rv=%b se=%b, want 1000 1000 0",
               ack, rv, se);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] ord [12];
    logic [3:0] exp_o [12];
    int n;
    exp_o = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
              4'b0001, 4'b0010, 4'b0100, 4'b1000,
              4'b0010, 4'b1000, 4'b0010, 4'b1000};
    do_reset();
    for (int i = 0; i < 4; i++)
      set_payload(i, 1'b0, 32'(i * 4), 32'h0, 4'h0, 3'd0);
    for (int i = 0; i < 12; i++) ord[i] = 4'h0;
    n = 0;
    req_valid = 4'hF;
    for (int k = 0; k < 200 && n < 8; k++) begin
      @(negedge PCLK);
      if (req_ack != 4'h0) begin ord[n] = req_ack; n++; end
    end
    req_valid = 4'b1010;
    for (int k = 0; k < 200 && n < 12; k++) begin
      @(negedge PCLK);
      if (req_ack != 4'h0) begin ord[n] = req_ack; n++; end
    end
    drain(10);
    for (int i = 0; i < 12; i++) begin
      vecs++;
      if (ord[i] !== exp_o[i]) begin
        errs++;
        $display("FAIL rr_order[%0d]: got %b, want %b", i, ord[i], exp_o[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t [3];
    int n;
    set_payload(2, 1'b0, 32'h8, 32'h0, 4'h0, 3'd0);
    for (int i = 0; i < 3; i++) t[i] = 0;
    n = 0;
    req_valid = 4'b0100;
    for (int k = 0; k < 100 && n < 3; k++) begin
      @(negedge PCLK);
      if (req_ack == 4'b0100) begin t[n] = cyc; n++; end
    end
    drain(10);
    vecs++;
    if (n != 3 || t[1] - t[0] != 5 || t[2] - t[1] != 5) begin
      errs++;
      $display("FAIL b2b_period: got n=%0d gaps %0d %0d, want 3 acks gap 5",
               n, t[1] - t[0], t[2] - t[1]);
    end
  endtask

  task automatic test_watchdog();
    logic [3:0] ack, rv; logic [31:0] sa, rd; logic se, to; int lat, wn;
    stall = 1'b1;
    run_xfer(2, 1'b0, 32'h8, 32'h0, 4'h0,
             ack, lat, sa, rv, rd, se, to, wn);
    vecs++;
    if (wn != 16) begin
      errs++;
      $display("FAIL wd_wait_cycles: got %0d, want 16", wn);
    end
    vecs++;
    if (rv !== 4'b0100 || rd !== 32'h0 || se !== 1'b1 || to !== 1'b1) begin
      errs++;
      $display("FAIL wd_rsp: got rv=%b rd=%h se=%b to=%b, want 0100 0 1 1",
               rv, rd, se, to);
    end
    stall = 1'b0;
    repeat (3) @(negedge PCLK);
  endtask

  task automatic test_reset_mid_wait();
    int seen;
    logic [3:0] first;
    stall = 1'b1;
    set_payload(1, 1'b1, 32'h30, 32'hA5A5A5A5, 4'hF, 3'd5);
    req_valid = 4'b0010;
    for (int k = 0; k < 20 && req_ack == 4'h0; k++) @(negedge PCLK);
    req_valid = 4'h0;
    for (int k = 0; k < 20 && transfer; k++) @(negedge PCLK);
    repeat (2) @(negedge PCLK);
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    vecs++;
    if ({req_ack, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
         transfer, SWRITE, SADDR, SWDATA, SSTRB, SPROT} !== 115'h0) begin
      errs++;
      $display("FAIL midreset_outputs: got se=%b to=%b sa=%h wd=%h st=%h sp=%h, want all 0",
               rsp_slverr, rsp_timeout, SADDR, SWDATA, SSTRB, SPROT);
    end
    stall = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge PCLK);
      if (rsp_valid != 4'h0) seen++;
    end
    vecs++;
    if (seen != 0) begin
      errs++;
      $display("FAIL midreset_no_rsp: got %0d responses, want 0", seen);
    end
    for (int i = 0; i < 4; i++)
      set_payload(i, 1'b0, 32'(i * 4), 32'h0, 4'h0, 3'd0);
    first = 4'h0;
    req_valid = 4'hF;
    for (int k = 0; k < 20 && first == 4'h0; k++) begin
      @(negedge PCLK);
      if (req_ack != 4'h0) first = req_ack;
    end
    drain(10);
    vecs++;
    if (first !== 4'b0001) begin
      errs++;
      $display("FAIL midreset_rrptr: got first ack %b, want 0001", first);
    end
  endtask

  initial begin
    cyc = 0; vecs = 0; errs = 0;
    stall = 1'b0;
    PRESET = 1'b1;
    req_valid = 4'h0; req_write = 4'h0;
    req_addr = '0; req_wdata = '0; req_strb = '0; req_prot = '0;
    test_reset();
    test_single_write();
    test_read_back();
    test_slave_error();
    test_round_robin();
    test_back_to_back();
    test_watchdog();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
